// File: rtl/data_ram.sv
// Byte-banked word memory for the MEM-stage load/store port. Loads are combinational
// and stores commit on the clock edge. A zeroing sweep runs after reset, and the first illegal access is recorded.
module data_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic [0:0]  dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic                  busy;
  logic                  fault;
  logic                  acc_ok;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [3:0]            wr_lane;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;

  assign busy   = (state_q == ST_INIT);
  assign idx    = addr_i[ADDR_WIDTH+1:2];
  assign fault  = ce_i & ~busy &
                  ((addr_i[1:0] != 2'b00) | (addr_i[31:ADDR_WIDTH+2] != '0));
  assign acc_ok = ce_i & ~busy & ~fault;

  // The sweep counter wraps to zero on its last step, so READY always sees cnt = 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (&cnt_q) begin
        state_d = ST_READY;
      end
    end
  end

  always_comb begin
    err_d      = err_q | fault;
    err_addr_d = err_addr_q;
    if (fault && !err_q) begin
      err_addr_d = addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // One shared write port: the sweep owns it while busy, the MEM stage afterwards.
  always_comb begin
    wr_lane = 4'b0000;
    wr_idx  = idx;
    wr_data = data_i;
    if (busy) begin
      wr_lane = 4'b1111;
      wr_idx  = cnt_q;
      wr_data = '0;
    end else if (acc_ok && we_i) begin
      wr_lane = sel_i;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_lane[k]) begin
        mem[wr_idx] <= wr_data[8*k +: 8];
      end
    end

    assign rd_word[8*k +: 8] = (acc_ok && !we_i && sel_i[k]) ? mem[idx] : 8'h00;
  end

  assign data_o      = rd_word;
  assign busy_o      = busy;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram (ADDR_WIDTH=4): the driver pushes the expected load data for
// every access, and the monitor pops and compares it on the falling edge.
module tb_data_ram;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        busy_o;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic [0:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: word array, busy flag and sticky error record.
  logic [31:0] mdl_mem [16];
  bit          mdl_busy;
  bit          mdl_err;
  logic [31:0] mdl_err_addr;

  data_ram #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .busy_o(busy_o),
    .err_o(err_o), .err_addr_o(err_addr_o), .dbg_state_o(dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with ce_i high presents a load result.
  always @(negedge clk) begin
    if (ce_i === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL data_o: access with no expected entry, got %h", data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL data_o: addr %h sel %b we %b got %h expected %h",
                   addr_i, sel_i, we_i, data_o, e);
        end
      end
    end
  end

  function automatic bit is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:6] != 26'd0);
  endfunction

  // Called just after a rising edge; drives one access for one cycle.
  task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data);
    logic [31:0] exp;
    int w;
    bit flt;
    flt = is_fault(addr);
    w   = int'(addr[5:2]);
    exp = 32'h0;
    if (!mdl_busy && !flt && !we) begin
      for (int k = 0; k < 4; k++)
        if (sel[k]) exp[8*k +: 8] = mdl_mem[w][8*k +: 8];
    end
    ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    ce_i = 1'b0; we_i = 1'b0;
    if (!mdl_busy) begin
      if (flt) begin
        if (!mdl_err) mdl_err_addr = addr;
        mdl_err = 1'b1;
      end else if (we) begin
        for (int k = 0; k < 4; k++)
          if (sel[k]) mdl_mem[w][8*k +: 8] = data[8*k +: 8];
      end
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, {31'd0, mdl_busy});
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, mdl_err});
    check({tag, "_err_addr"}, err_addr_o, mdl_err_addr);
  endtask

  // Hold reset for two cycles, then release just after a rising edge.
  task automatic apply_reset();
    rst = 1'b0;
    mdl_busy = 1'b1; mdl_err = 1'b0; mdl_err_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_flags("in_reset");
    rst = 1'b1;
  endtask

  // Count sweep edges from reset release; optionally issue a store while busy.
  task automatic wait_init(input string tag, input bit with_write);
    int n;
    n = 0;
    if (with_write) begin
      ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h4; sel_i = 4'hF; data_i = 32'hCAFEF00D;
      exp_q.push_back(32'h0);
    end
    while (busy_o === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      ce_i = 1'b0; we_i = 1'b0;
      n++;
    end
    check({tag, "_init_edges"}, n, 16);
    for (int i = 0; i < 16; i++) mdl_mem[i] = 32'h0;
    mdl_busy = 1'b0;
    check_flags({tag, "_after_init"});
  endtask

  task automatic read_all(input logic [3:0] sel);
    for (int i = 0; i < 16; i++) access(1'b0, 32'(i * 4), sel, 32'h0);
  endtask

  initial begin
    rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; sel_i = 4'h0; data_i = 32'h0;
    mdl_busy = 1'b1; mdl_err = 1'b0; mdl_err_addr = 32'h0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_flags("reset");
    check("reset_data_o", data_o, 32'h0);
    rst = 1'b1;
    wait_init("first", 1'b0);
    read_all(4'hF);

    // Directed lane tests.
    access(1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
    access(1'b0, 32'h8, 4'hF, 32'h0);
    check("model_deadbeef", mdl_mem[2], 32'hDEADBEEF);
    access(1'b1, 32'h8, 4'b0010, 32'h00005500);
    access(1'b0, 32'h8, 4'hF, 32'h0);
    access(1'b0, 32'h8, 4'b0001, 32'h0);

    // Random legal traffic.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
    end
    check_flags("after_random");

    // Misaligned store: nothing written, error latched with its address.
    access(1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
    access(1'b1, 32'h8, 4'b0010, 32'h00005500);
    access(1'b1, 32'hA, 4'hF, 32'h11111111);
    check("err_after_misaligned", {31'd0, err_o}, 32'd1);
    check("err_addr_misaligned", err_addr_o, 32'h0000000A);
    access(1'b0, 32'h8, 4'hF, 32'h0);
    access(1'b0, 32'h40, 4'hF, 32'h0);
    check("err_addr_sticky", err_addr_o, 32'h0000000A);

    // Random mix including faulting addresses.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 2))
        0: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        1: a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
        default: a = $urandom() | 32'h40;
      endcase
      access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
    end
    check_flags("after_faults");

    // Reset in the middle of the sweep restarts it.
    @(posedge clk); #1;
    apply_reset();
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_init", {31'd0, busy_o}, 32'd1);
    apply_reset();
    wait_init("restart", 1'b1);
    access(1'b0, 32'h4, 4'hF, 32'h0);
    check_flags("after_busy_write");

    // Fill, reset, and confirm the sweep clears everything.
    for (int i = 0; i < 16; i++) access(1'b1, 32'(i * 4), 4'hF, 32'h01010101 * 32'(i));
    read_all(4'hF);
    @(posedge clk); #1;
    apply_reset();
    wait_init("refill", 1'b0);
    read_all(4'hF);
    check_flags("final");

    repeat (2) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram.md
# data_ram

Byte-banked data memory that sits on the responder side of the MEM-stage load/store port. It accepts the MEM stage's chip-enable, write-enable, byte-select, address and store-data signals and returns load data combinationally in the same cycle. Stores commit on the rising clock edge. After reset it runs an initialisation sweep that zeroes every word, and it keeps a sticky error record for illegal accesses.

## Interface
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ce_i  in  1  chip enable from MEM stage (1 = access this cycle)
- we_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address
- sel_i  in  4  byte-lane select; lane k = bits [8k+7:8k]
- data_i  in  32  store data
- data_o  out  32  load data, combinational
- busy_o  out  1  1 while the init sweep runs; accesses are ignored
- err_o  out  1  sticky illegal-access flag
- err_addr_o  out  32  byte address of the first illegal access

## Operation
- Storage consists of four byte banks (bank k holds lane k), each 2^ADDR_WIDTH deep.
- Word index idx = addr_i[ADDR_WIDTH+1:2].
- Fault condition: ce_i & !busy_o & (addr_i[1:0] != 0 | addr_i[31:ADDR_WIDTH+2] != 0).
- FSM states:
  - INIT: counter cnt sweeps 0 to DEPTH-1. Each cycle, all four banks at cnt are written with 0 and busy_o = 1. When the edge that writes cnt == DEPTH-1 occurs, the FSM moves to READY and cnt returns to 0.
  - READY: busy_o = 0; normal service. READY is held until reset.
- Reset assertion (any time, including mid-INIT) forces INIT with cnt = 0. Memory contents are not cleared asynchronously; the sweep clears them.
- Write (READY, ce_i=1, we_i=1, no fault): at the rising edge, for each k with sel_i[k]=1, bank k[idx] <= data_i[8k+7:8k]. Lanes with sel_i[k]=0 are unchanged.
- Read (READY, ce_i=1, we_i=0, no fault): data_o lane k = bank k[idx] if sel_i[k]=1, else 8'h00.
- data_o = 0 whenever ce_i=0, we_i=1, busy_o=1, or a fault is present.
- Faulting access:
  - No bank is written.
  - At the edge, err_o <= 1.
  - If err_o was 0, err_addr_o <= addr_i; later faults do not overwrite it.
  - err_o and err_addr_o clear only on reset.
- Accesses during INIT are silently dropped: no write, no error, data_o = 0.
- Only one access is made per cycle. A read in the cycle after a write to the same word returns the new bytes.

## Timing
- Reset values: busy_o=1, err_o=0, err_addr_o=0, cnt=0, state=INIT; data_o=0 (busy).
- Init latency is exactly 2^ADDR_WIDTH rising edges after reset release. busy_o falls after the last of them.
- Read latency is 0: data_o is combinational from addr_i/sel_i/ce_i/we_i and bank contents.
- Write latency is 1: the value is visible to a read in the next cycle.
- err_o rises on the edge ending the faulting cycle and is not combinational.

## Test plan
- ADDR_WIDTH=4. Release reset, count busy_o=1 edges, then read all words with sel=1111 -> busy exactly 16 edges; every read returns 0x00000000.
- Write 0xDEADBEEF, sel 1111, addr 0x08; next cycle read addr 0x08 sel 1111 -> data_o=0xDEADBEEF.
- Write data 0x00005500, sel 0010, addr 0x08; read sel 1111 -> 0xDEAD55EF; read sel 0001 -> 0x000000EF.
- Write 0x11111111 to addr 0x0A (misaligned) -> word 0x08 still reads 0xDEAD55EF; err_o=1 after that edge, err_addr_o=0x0000000A. Then read addr 0x40 (out of range) -> data_o=0, err_addr_o stays 0x0000000A.
- Assert reset at init edge 5 for 2 cycles, release -> busy_o stays 1 throughout; sweep restarts and takes 16 more edges. A write to addr 0x04 issued during busy is dropped (reads 0 afterwards) and err_o stays 0.
- Fill all 16 words with their index pattern (word i = 0x0101_0101*i), then assert reset and let init complete -> all words read 0; err_o=0.
